// File: rtl/cnn_frame_seq_if.sv
// BRAM read port and line-buffer pixel/window signals of the CNN stage-1 frame sequencer.
// The master side is the sequencer; the slave side is the BRAM plus line buffer.
interface cnn_frame_seq_if #(
    parameter int ADDR_BW = 10,
    parameter int PIX_BW  = 8
);
    logic               o_mem_rd_en;
    logic [ADDR_BW-1:0] o_mem_addr;
    logic [PIX_BW-1:0]  i_mem_rd_data;
    logic               o_lb_valid;
    logic [PIX_BW-1:0]  o_lb_pixel;
    logic               i_lb_window_valid;

    modport master (
        output o_mem_rd_en, o_mem_addr, o_lb_valid, o_lb_pixel,
        input  i_mem_rd_data, i_lb_window_valid
    );

    modport slave (
        input  o_mem_rd_en, o_mem_addr, o_lb_valid, o_lb_pixel,
        output i_mem_rd_data, i_lb_window_valid
    );
endinterface

// File: rtl/cnn_frame_seq.sv
// Frame sequencer for CNN stage 1: streams one IX x IY image from BRAM into the line buffer
// and counts returned windows. Define CNN_SEQ_TIMEOUT_EN to build the drain timeout.
module cnn_frame_seq #(
    parameter int IX          = 28,
    parameter int IY          = 28,
    parameter int KX          = 5,
    parameter int KY          = 5,
    parameter int PIX_BW      = 8,
    parameter int MEM_LAT     = 1,
    parameter int TIMEOUT_CYC = 1024,
    localparam int NPIX       = IX * IY,
    localparam int NWIN       = (IX - KX + 1) * (IY - KY + 1),
    localparam int ADDR_BW    = $clog2(NPIX),
    localparam int WIN_BW     = $clog2(NWIN + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic              i_stall,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [WIN_BW-1:0] o_win_cnt,
    cnn_frame_seq_if.master   bus
);

    // state   | meaning
    // S_IDLE  | waiting for i_start
    // S_FETCH | issuing BRAM reads in raster order
    // S_DRAIN | reads done, waiting for pipeline empty and all windows
    // S_DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_rd_en;
    logic [ADDR_BW-1:0] r_addr;
    logic [MEM_LAT-1:0] r_vld_sr;
    logic [MEM_LAT-1:0] w_vld_sr_nxt;
    logic [PIX_BW-1:0]  r_pix_hold;
    logic [WIN_BW-1:0]  r_win_cnt;
    logic [WIN_BW-1:0]  w_win_cnt_nxt;
    logic               w_start;
    logic               w_last_rd;
    logic               w_win_inc;
    logic               w_drained;
    logic               w_timeout;
    logic               w_err;
    logic               w_lb_valid;

    assign w_start      = (r_state == S_IDLE) && i_start;
    assign w_last_rd    = (r_state == S_FETCH) && r_rd_en && (r_addr == ADDR_BW'(NPIX - 1));
    assign w_lb_valid   = r_vld_sr[MEM_LAT-1];
    assign w_vld_sr_nxt = (r_vld_sr << 1) | MEM_LAT'(r_rd_en);
    assign w_win_inc    = bus.i_lb_window_valid && (r_win_cnt != WIN_BW'(NWIN))
                          && ((r_state == S_FETCH) || (r_state == S_DRAIN));

    always_comb begin
        w_win_cnt_nxt = r_win_cnt;
        if (w_start) begin
            w_win_cnt_nxt = '0;
        end else if (w_win_inc) begin
            w_win_cnt_nxt = r_win_cnt + WIN_BW'(1);
        end
    end

    // Looking at next-cycle values lets DONE follow the last window or last pixel by one cycle.
    assign w_drained = (w_win_cnt_nxt == WIN_BW'(NWIN)) && (w_vld_sr_nxt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_FETCH;
            S_FETCH: if (w_last_rd) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drained || w_timeout) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy          = (r_state != S_IDLE);
        o_done          = (r_state == S_DONE);
        o_err           = w_err;
        o_win_cnt       = r_win_cnt;
        bus.o_mem_rd_en = r_rd_en;
        bus.o_mem_addr  = r_addr;
        bus.o_lb_valid  = w_lb_valid;
        bus.o_lb_pixel  = w_lb_valid ? bus.i_mem_rd_data : r_pix_hold;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_en    <= 1'b0;
            r_addr     <= '0;
            r_vld_sr   <= '0;
            r_pix_hold <= '0;
            r_win_cnt  <= '0;
        end else begin
            r_rd_en  <= (w_state_nxt == S_FETCH) && !i_stall;
            r_vld_sr <= w_vld_sr_nxt;
            r_win_cnt <= w_win_cnt_nxt;
            if (w_start) begin
                r_addr <= '0;
            end else if ((r_state == S_FETCH) && r_rd_en && !w_last_rd) begin
                r_addr <= r_addr + ADDR_BW'(1);
            end
            if (w_lb_valid) begin
                r_pix_hold <= bus.i_mem_rd_data;
            end
        end
    end

`ifdef CNN_SEQ_TIMEOUT_EN
    localparam int TMO_BW = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_BW-1:0] r_tmo_cnt;
    logic              r_err;

    assign w_timeout = (r_state == S_DRAIN) && (r_tmo_cnt == '0);
    assign w_err     = r_err;

    // Preloaded outside DRAIN so terminal count lands on the TIMEOUT_CYC-th drain cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state != S_DRAIN) begin
                r_tmo_cnt <= TMO_BW'(TIMEOUT_CYC - 1);
            end else if (r_tmo_cnt != '0) begin
                r_tmo_cnt <= r_tmo_cnt - TMO_BW'(1);
            end
            if (w_start) begin
                r_err <= 1'b0;
            end else if (w_timeout && !w_drained) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_err     = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_frame_seq.sv
// Bench for cnn_frame_seq: BRAM and line-buffer models, a frame-level reference model
// checked every cycle, and directed scenarios with hand-computed timing.
module tb_cnn_frame_seq;
    localparam int IX = 8, IY = 8, KX = 3, KY = 3, PIX_BW = 8, MEM_LAT = 2, TIMEOUT_CYC = 50;
    localparam int NPIX = 64, NWIN = 36, ADDR_BW = 6, WIN_BW = 6;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              i_start = 1'b0;
    logic              i_stall = 1'b0;
    logic              o_busy, o_done, o_err;
    logic [WIN_BW-1:0] o_win_cnt;

    cnn_frame_seq_if #(.ADDR_BW(ADDR_BW), .PIX_BW(PIX_BW)) bus ();

    cnn_frame_seq #(
        .IX(IX), .IY(IY), .KX(KX), .KY(KY), .PIX_BW(PIX_BW),
        .MEM_LAT(MEM_LAT), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_stall(i_stall),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_win_cnt(o_win_cnt),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // BRAM holding pixel value = address, MEM_LAT-cycle read latency
    logic [ADDR_BW-1:0] bram_q [MEM_LAT];
    always @(posedge clk) begin
        if (bus.o_mem_rd_en) bram_q[0] <= bus.o_mem_addr;
        for (int i = 1; i < MEM_LAT; i++) bram_q[i] <= bram_q[i-1];
    end
    assign bus.i_mem_rd_data = PIX_BW'(bram_q[MEM_LAT-1]);

    // Line buffer: one window, one cycle after each pixel whose KXxKY neighbourhood is complete
    int   lb_pix, lb_sent;
    int   lb_limit = NWIN;
    logic lb_wv;
    always @(posedge clk or negedge reset_n) begin
        int sent;
        if (!reset_n) begin
            lb_pix <= 0; lb_sent <= 0; lb_wv <= 1'b0;
        end else begin
            lb_wv <= 1'b0;
            if (bus.o_lb_valid) begin
                sent = (lb_pix == 0) ? 0 : lb_sent;
                if ((lb_pix % IX) >= KX - 1 && (lb_pix / IX) >= KY - 1 && sent < lb_limit) begin
                    lb_wv <= 1'b1;
                    sent++;
                end
                lb_sent <= sent;
                lb_pix  <= (lb_pix == NPIX - 1) ? 0 : lb_pix + 1;
            end
        end
    end
    assign bus.i_lb_window_valid = lb_wv;

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    bit busy_m = 1'b0, err_m = 1'b0, stall_prev = 1'b0;
    int exp_rd, exp_pix, exp_win, last_win_cyc, last_vld_cyc, last_rd_cyc;
    int start_cyc, first_vld_cyc, done_cyc, done_cnt = 0;

    task automatic check_eq(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        int exp_done;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                busy_m = 0; err_m = 0; stall_prev = 0;
                exp_rd = 0; exp_pix = 0; exp_win = 0;
            end else begin
                check_eq("busy", o_busy, busy_m);
                check_eq("win_cnt", o_win_cnt, exp_win);
                check_eq("err", o_err, err_m);
                if (stall_prev) check_eq("rd_en_under_stall", bus.o_mem_rd_en, 0);
                if (bus.o_mem_rd_en) begin
                    check_eq("rd_addr", bus.o_mem_addr, exp_rd);
                    exp_rd++;
                    last_rd_cyc = cyc;
                end
                if (bus.o_lb_valid) begin
                    check_eq("lb_pixel", bus.o_lb_pixel, exp_pix % 256);
                    if (exp_pix == 0) first_vld_cyc = cyc;
                    exp_pix++;
                    last_vld_cyc = cyc;
                end
                if (o_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    exp_done = ((last_win_cyc > last_vld_cyc) ? last_win_cyc : last_vld_cyc) + 1;
`ifdef CNN_SEQ_TIMEOUT_EN
                    if (exp_win < NWIN) exp_done = last_rd_cyc + 1 + TIMEOUT_CYC;
`endif
                    check_eq("done_cycle", cyc, exp_done);
                    check_eq("done_pixels_delivered", exp_pix, NPIX);
                end
                if (bus.i_lb_window_valid && busy_m && !o_done && exp_win < NWIN) begin
                    exp_win++;
                    last_win_cyc = cyc;
                end
`ifdef CNN_SEQ_TIMEOUT_EN
                if (busy_m && !o_done && exp_rd == NPIX && exp_win < NWIN
                    && cyc == last_rd_cyc + TIMEOUT_CYC) err_m = 1;
`endif
                if (o_done) begin
                    busy_m = 0;
                end else if (!busy_m && i_start) begin
                    busy_m = 1; err_m = 0; start_cyc = cyc;
                    exp_rd = 0; exp_pix = 0; exp_win = 0; last_win_cyc = 0; last_vld_cyc = 0;
                end
                stall_prev = i_stall;
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        check_eq(name, {o_busy, o_done, o_err, bus.o_mem_rd_en, bus.o_lb_valid,
                        bus.o_mem_addr, o_win_cnt, bus.o_lb_pixel}, 0);
    endtask

    initial begin
        bit ok;
        int d0, trail;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_all_zero("idle_outputs");
        end

        // plain frame
        d0 = done_cnt;
        pulse_start();
        wait_done(200, ok);
        check_eq("f1_done_seen", ok, 1);
        check_eq("f1_win_at_done", o_win_cnt, 36);
        check_eq("f1_err_at_done", o_err, 0);
        check_eq("f1_first_valid_latency", first_vld_cyc - start_cyc, 3);
        check_eq("f1_rd_cycles", exp_rd, 64);
        check_eq("f1_rd_contiguous", last_rd_cyc - start_cyc, 64);
        check_eq("f1_done_latency", done_cyc - start_cyc, 68);
        repeat (5) @(negedge clk);
        check_eq("f1_done_count", done_cnt - d0, 1);
        check_eq("f1_busy_after", o_busy, 0);

        // five-cycle stall with address 20 pending
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk); #1;
            ok = bus.o_mem_rd_en && (bus.o_mem_addr == 19);
        end
        check_eq("stall_reached_addr19", ok, 1);
        i_stall = 1'b1;
        trail = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("stall_addr_hold", bus.o_mem_addr, 20);
            check_eq("stall_rd_en", bus.o_mem_rd_en, 0);
            if (bus.o_lb_valid) trail++;
        end
        i_stall = 1'b0;
        check_eq("stall_trailing_valid", trail, 2);
        wait_done(200, ok);
        check_eq("f2_done_seen", ok, 1);
        check_eq("f2_win_at_done", o_win_cnt, 36);
        check_eq("f2_done_latency", done_cyc - start_cyc, 73);

        // extra start while busy; start held through DONE and the following IDLE cycle
        d0 = done_cnt;
        pulse_start();
        repeat (20) @(posedge clk);
        #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        wait_done(200, ok);
        check_eq("f3_done_seen", ok, 1);
        check_eq("f3_rd_cycles", exp_rd, 64);
        #1 i_start = 1'b1;
        @(posedge clk); #1;
        check_eq("start_in_done_ignored", o_busy, 0);
        @(posedge clk); #1 i_start = 1'b0;
        check_eq("start_in_idle_accepted", o_busy, 1);
        check_eq("f3_single_done", done_cnt - d0, 1);

        // reset mid-frame at address 30
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk); #1;
            ok = (bus.o_mem_addr == 30);
        end
        check_eq("reset_reached_addr30", ok, 1);
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_reset_outputs");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("no_done_after_reset", done_cnt - d0, 0);
        pulse_start();
        wait_done(200, ok);
        check_eq("f4_done_seen", ok, 1);
        check_eq("f4_win_at_done", o_win_cnt, 36);
        check_eq("f4_done_latency", done_cyc - start_cyc, 68);

`ifdef CNN_SEQ_TIMEOUT_EN
        lb_limit = 10;
        pulse_start();
        wait_done(300, ok);
        check_eq("tmo_done_seen", ok, 1);
        check_eq("tmo_err_at_done", o_err, 1);
        check_eq("tmo_win_at_done", o_win_cnt, 10);
        check_eq("tmo_done_after_drain", done_cyc - (last_rd_cyc + 1), 50);
        lb_limit = NWIN;
        pulse_start();
        @(negedge clk);
        check_eq("tmo_err_cleared", o_err, 0);
        wait_done(200, ok);
        check_eq("tmo_next_done_seen", ok, 1);
        check_eq("tmo_next_win", o_win_cnt, 36);
`endif

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cnn_frame_seq.md
# cnn_frame_seq

Frame sequencer for CNN stage 1. On a start pulse it reads one IX×IY input image from the pixel BRAM in raster order and streams it into the KX×KY line-buffer/window generator. It counts the windows the line buffer returns, then signals frame completion. It sits between the AXI-loaded image BRAM and the line buffer and conv core, and is the only block that drives the line buffer's pixel input.

## Interface
Parameters:
- IX, 28, image width in pixels
- IY, 28, image height in pixels
- KX, 5, kernel width
- KY, 5, kernel height
- PIX_BW, 8, pixel width in bits
- MEM_LAT, 1, BRAM read latency in cycles (≥1)
- TIMEOUT_CYC, 1024, drain timeout in cycles (used only with CNN_SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- i_start  in  1  one-cycle start request
- i_stall  in  1  downstream hold; suspends new BRAM reads
- o_busy  out  1  high from the cycle after an accepted start until done
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  sticky timeout flag; cleared by the next accepted start
- o_mem_rd_en  out  1  BRAM read enable
- o_mem_addr  out  $clog2(IX*IY)  BRAM read address
- i_mem_rd_data  in  PIX_BW  BRAM read data, valid MEM_LAT cycles after rd_en
- o_lb_valid  out  1  pixel valid to the line buffer
- o_lb_pixel  out  PIX_BW  pixel to the line buffer
- i_lb_window_valid  in  1  window-valid from the line buffer
- o_win_cnt  out  $clog2(NWIN+1)  windows received this frame

## Operation
- Derived values: NPIX = IX*IY and NWIN = (IX-KX+1)*(IY-KY+1).
- FSM states are IDLE, FETCH, DRAIN and DONE.
- IDLE:
  - i_start moves the FSM to FETCH.
  - Starting a frame clears o_mem_addr, o_win_cnt and o_err.
- FETCH:
  - When i_stall is low: o_mem_rd_en = 1 and o_mem_addr increments by 1 each cycle.
  - When i_stall is high: o_mem_rd_en = 0 and the address holds.
  - A read issued at address NPIX-1 moves the FSM to DRAIN.
- Read pipeline:
  - rd_en is delayed through a MEM_LAT-deep shift register to produce o_lb_valid.
  - o_lb_pixel = i_mem_rd_data, passed through combinationally and aligned with o_lb_valid.
  - Reads already in flight are always delivered, regardless of i_stall.
- DRAIN:
  - No reads are issued.
  - The FSM moves to DONE once o_win_cnt == NWIN and the read pipeline is empty.
- DONE: o_done = 1 for one cycle, then the FSM returns to IDLE.
- Window counting:
  - o_win_cnt increments on each i_lb_window_valid while in FETCH or DRAIN.
  - The count saturates at NWIN; extra windows are ignored.
  - i_lb_window_valid is ignored in IDLE and DONE.
- i_start is ignored while o_busy is high.
- o_busy = 1 in FETCH, DRAIN and DONE.

## Timing
- Reset values: FSM = IDLE. o_busy, o_done, o_err, o_mem_rd_en and o_lb_valid are 0. o_mem_addr and o_win_cnt are 0. o_lb_pixel is 0 (sourced from a registered hold of the last valid pixel).
- Start sequence: i_start is sampled at edge T. At T+1, o_busy = 1, o_mem_rd_en = 1 and o_mem_addr = 0. At T+1+MEM_LAT, o_lb_valid = 1 with pixel 0.
- Unstalled frame: exactly NPIX consecutive rd_en cycles.
- Stall: i_stall high at edge T deasserts rd_en at T+1. Valid output continues for MEM_LAT cycles afterwards.
- Done timing: o_done is asserted one cycle after the last counted window, or after the pipeline empties, whichever is later.
- Reset mid-frame: outputs return to their reset values immediately (asynchronous reset). No o_done is produced.
- Start coincident with DONE: the start is ignored. A new start is accepted from the IDLE cycle onward.

## Configuration
- CNN_SEQ_TIMEOUT_EN defined:
  - A drain counter runs while in DRAIN.
  - After TIMEOUT_CYC cycles without reaching NWIN, the block sets o_err = 1 and moves to DONE, which pulses o_done.
- CNN_SEQ_TIMEOUT_EN undefined:
  - No timeout counter is built; DRAIN waits indefinitely.
  - o_err is tied to 0.

## Test plan
Bench parameters: IX=IY=8, KX=KY=3, MEM_LAT=2 (NPIX=64, NWIN=36).
- Reset then idle for 10 cycles -> every output stays 0, o_busy = 0.
- Single start with no stall, line buffer model attached -> 64 rd_en cycles, addresses 0..63. o_lb_valid starts 3 cycles after the start edge. o_win_cnt reaches 36, o_done pulses once, o_err = 0.
- i_stall high for 5 cycles at address 20 -> address holds at 20, 2 trailing valid pixels are delivered, and the pixel sequence into the line buffer is unchanged (BRAM contains addr-value pattern).
- Second i_start pulse while busy -> ignored: only one frame is run and one o_done is produced.
- Reset asserted at address 30 -> all outputs go to 0 immediately. A subsequent start runs a full clean frame with o_win_cnt = 36.
- With CNN_SEQ_TIMEOUT_EN and TIMEOUT_CYC=50, only 10 windows returned -> o_err = 1 and o_done pulses 50 cycles after entering DRAIN. The next start clears o_err.
